// File: rtl/ysyx_25020037_icache_l1.sv
// ysyx_25020037_icache_l1
// Direct-mapped, one-word-per-line L1 instruction cache placed in front of the IFU.
// A lookup either returns a one-cycle hit pulse with held data, or raises mem_req so the
// IFU fetches over AXI. While it waits, the cache snoops the returning beat to refill the line.
// A fence.i flush invalidates every line. Hit and miss counters are kept for performance work.
module ysyx_25020037_icache_l1 #(
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 30 - INDEX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        icache_req,
  input  logic        flush,
  output logic        icache_hit,
  output logic [31:0] icache_data,
  output logic        icache_ready,
  output logic        mem_req,
  input  logic        mem_ready,
  input  logic [31:0] rdata,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MISS
  } state_t;

  state_t state;
  state_t state_next;

  // The byte offset of a word fetch carries no information for this cache.
  logic unused_pc_bits;
  assign unused_pc_bits = ^pc[1:0];

  // Word address of the request being served (pc[31:2]).
  logic [29:0]        req_addr;
  logic [INDEX_W-1:0] req_idx;
  logic [TAG_W-1:0]   req_tag;

  assign req_idx = req_addr[INDEX_W-1:0];
  assign req_tag = req_addr[INDEX_W +: TAG_W];

  // Line storage: only the valid bits need a reset value.
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_arr  [LINES];
  logic [31:0]      data_arr [LINES];

  // Remembers a flush that arrived while a refill was outstanding, so the
  // refilled line is not marked valid with pre-flush contents.
  logic flush_seen;

  // Per-cycle decisions shared by the next-state logic and the datapath.
  logic lookup_hit;
  logic take_req;
  logic do_hit;
  logic do_miss;
  logic do_refill;

  // State register; reset abandons any refill in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection for the IDLE / LOOKUP / MISS sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (take_req) begin
          state_next = LOOKUP;
        end
      end
      LOOKUP: begin
        if (do_hit) begin
          state_next = IDLE;
        end else begin
          state_next = MISS;
        end
      end
      MISS: begin
        if (do_refill) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Decode the current state into strobes; a flush in the lookup cycle forces a miss.
  always_comb begin
    lookup_hit   = valid[req_idx] && (tag_arr[req_idx] == req_tag) && !flush;
    take_req     = 1'b0;
    do_hit       = 1'b0;
    do_miss      = 1'b0;
    do_refill    = 1'b0;
    icache_ready = 1'b1;
    case (state)
      IDLE: begin
        take_req = icache_req;
      end
      LOOKUP: begin
        do_hit       = lookup_hit;
        do_miss      = !lookup_hit;
        icache_ready = 1'b0;
      end
      MISS: begin
        do_refill = mem_ready;
      end
      default: begin
        icache_ready = 1'b1;
      end
    endcase
  end

  // Capture the fetch address only when a new lookup is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_addr <= '0;
    end else if (take_req) begin
      req_addr <= pc[31:2];
    end
  end

  // Valid bits: refill sets the line unless a flush intervened; a flush always wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else begin
      if (do_refill) begin
        valid[req_idx] <= !flush_seen;
      end
      if (flush) begin
        valid <= '0;
      end
    end
  end

  // Track flushes seen since the current miss began.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_seen <= 1'b0;
    end else if (do_miss) begin
      flush_seen <= 1'b0;
    end else if ((state == MISS) && flush) begin
      flush_seen <= 1'b1;
    end
  end

  // Tag and data arrays take the snooped AXI beat even when the line stays invalid.
  always_ff @(posedge clk) begin
    if (do_refill) begin
      tag_arr[req_idx]  <= req_tag;
      data_arr[req_idx] <= rdata;
    end
  end

  // Hit pulse and held instruction word; a refill leaves icache_data untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      icache_hit  <= 1'b0;
      icache_data <= '0;
    end else begin
      icache_hit <= do_hit;
      if (do_hit) begin
        icache_data <= data_arr[req_idx];
      end
    end
  end

  // Miss handshake toward the IFU: raised on a miss, dropped when the beat returns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req <= 1'b0;
    end else if (do_miss) begin
      mem_req <= 1'b1;
    end else if (do_refill) begin
      mem_req <= 1'b0;
    end
  end

  // Free-running wrap-around performance counters, one step per completed lookup.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (do_hit) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (do_miss) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end

endmodule
